// File: rtl/apb3_master_arbiter_pkg.sv
// Shared types and helpers for the APB3 master arbiter: FSM state encoding
// and the counter-width function.
package apb3_master_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/apb3_master_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr_i,
// wrapping modulo NUM_REQ. Returns a one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  always_comb begin
    int cand;
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    cand    = 0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(ptr_i) + off) % NUM_REQ;
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/apb3_master_arbiter.sv
// Shares one APB3 master port between NUM_REQ requesters with round-robin
// grant, SETUP/ACCESS sequencing, PREADY wait states and a PREADY timeout.
module apb3_master_arbiter
  import apb3_master_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_write;
  logic [DATA_W-1:0]   sel_wdata;

  // A requester still shows req in its done cycle, so that cycle is masked.
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i   (req & ~done_q),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    sel_addr  = '0;
    sel_write = 1'b0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_addr  = sel_addr  | req_addr[i*ADDR_W +: ADDR_W];
        sel_write = sel_write | req_write[i];
        sel_wdata = sel_wdata | req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    done_d    = '0;
    rdata_d   = '0;
    err_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d   = ST_SETUP;
          win_d     = arb_idx;
          ptr_d     = arb_idx;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = sel_addr;
          pwrite_d  = sel_write;
          pwdata_d  = sel_wdata;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          state_d       = ST_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          done_d[win_q] = 1'b1;
          err_d         = PSLVERR;
          rdata_d       = pwrite_q ? '0 : PRDATA;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d       = ST_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          done_d[win_q] = 1'b1;
          err_d         = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      win_q     <= '0;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign done      = done_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb3_master_arbiter.sv
// Directed bench for apb3_master_arbiter: two requesters, TIMEOUT=8, slave
// responses driven directly from each scenario task.
module tb_apb3_master_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic                      PCLK;
  logic                      PRESET;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      PSEL;
  logic                      PENABLE;
  logic [ADDR_W-1:0]         PADDR;
  logic                      PWRITE;
  logic [DATA_W-1:0]         PWDATA;
  logic [DATA_W-1:0]         PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  int n_checks = 0;
  int n_fail   = 0;

  apb3_master_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .done(done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .PSEL(PSEL), .PENABLE(PENABLE),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Advance one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  task automatic test_reset();
    PRESET = 1'b1; req = '0; req_addr = '0; req_write = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick(); tick();
    n_checks++; if (PSEL !== 1'b0) begin n_fail++; $display("FAIL reset_psel: got %0b want 0", PSEL); end
    n_checks++; if (PENABLE !== 1'b0) begin n_fail++; $display("FAIL reset_penable: got %0b want 0", PENABLE); end
    n_checks++; if (PADDR !== 32'h0) begin n_fail++; $display("FAIL reset_paddr: got %h want 0", PADDR); end
    n_checks++; if (PWRITE !== 1'b0 || PWDATA !== 32'h0) begin n_fail++; $display("FAIL reset_pwrite_pwdata: got %0b/%h want 0/0", PWRITE, PWDATA); end
    n_checks++; if (done !== 2'b00 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got done=%b rdata=%h err=%0b want 00/0/0", done, rsp_rdata, rsp_err); end
    PRESET = 1'b0;
    tick();
  endtask

  task automatic test_write_zero_wait();
    PREADY = 1'b1;
    req_addr[0 +: 32] = 32'h6000_0010; req_wdata[0 +: 32] = 32'hDEAD_BEEF; req_write[0] = 1'b1;
    req = 2'b01;
    tick();
    n_checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0) begin n_fail++; $display("FAIL wr_setup: got psel=%0b pen=%0b want 1/0", PSEL, PENABLE); end
    n_checks++; if (PADDR !== 32'h6000_0010 || PWRITE !== 1'b1 || PWDATA !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_payload: got %h/%0b/%h want 60000010/1/deadbeef", PADDR, PWRITE, PWDATA); end
    tick();
    n_checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1 || done !== 2'b00) begin n_fail++; $display("FAIL wr_access: got psel=%0b pen=%0b done=%b want 1/1/00", PSEL, PENABLE, done); end
    tick();
    n_checks++; if (done !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_done: got done=%b err=%0b rdata=%h want 01/0/0", done, rsp_err, rsp_rdata); end
    n_checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin n_fail++; $display("FAIL wr_release: got psel=%0b pen=%0b want 0/0", PSEL, PENABLE); end
    req = 2'b00;
    tick();
    n_checks++; if (done !== 2'b00 || PSEL !== 1'b0) begin n_fail++; $display("FAIL wr_pulse_len: got done=%b psel=%0b want 00/0", done, PSEL); end
    n_checks++; if (PADDR !== 32'h6000_0010) begin n_fail++; $display("FAIL wr_addr_hold: got %h want 60000010", PADDR); end
  endtask

  task automatic test_read_wait();
    PREADY = 1'b0; PRDATA = 32'h0;
    req_addr[32 +: 32] = 32'h6000_1000; req_write[1] = 1'b0; req_wdata[32 +: 32] = 32'h5555_5555;
    req = 2'b10;
    tick();
    n_checks++; if (PSEL !== 1'b1 || PADDR !== 32'h6000_1000 || PWRITE !== 1'b0) begin n_fail++; $display("FAIL rd_setup: got psel=%0b addr=%h wr=%0b want 1/60001000/0", PSEL, PADDR, PWRITE); end
    tick();
    for (int w = 0; w < 3; w++) begin
      tick();
      n_checks++; if (done !== 2'b00 || PENABLE !== 1'b1) begin n_fail++; $display("FAIL rd_wait%0d: got done=%b pen=%0b want 00/1", w, done, PENABLE); end
    end
    PREADY = 1'b1; PRDATA = 32'h0000_1234;
    tick();
    n_checks++; if (done !== 2'b10 || rsp_rdata !== 32'h0000_1234 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rd_done: got done=%b rdata=%h err=%0b want 10/00001234/0", done, rsp_rdata, rsp_err); end
    req = 2'b00; PRDATA = 32'h0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_order [4];
    int n_done;
    logic last_done;
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
    PREADY = 1'b1;
    req_addr[0 +: 32] = 32'h6000_0100; req_addr[32 +: 32] = 32'h6000_0200;
    req_write = 2'b11;
    req = 2'b11;
    n_done = 0; last_done = 1'b0;
    for (int cyc = 0; cyc < 30 && n_done < 4; cyc++) begin
      tick();
      if (last_done) begin
        n_checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0) begin n_fail++; $display("FAIL b2b_gap%0d: got psel=%0b pen=%0b want 1/0", n_done, PSEL, PENABLE); end
      end
      last_done = 1'b0;
      if (done !== 2'b00) begin
        n_checks++; if (done !== exp_order[n_done]) begin n_fail++; $display("FAIL b2b_order%0d: got done=%b want %b", n_done, done, exp_order[n_done]); end
        n_done++;
        last_done = (n_done < 4);
        if (n_done == 4) req = 2'b00;
      end
    end
    n_checks++; if (n_done != 4) begin n_fail++; $display("FAIL b2b_count: got %0d transfers want 4", n_done); end
    req = 2'b00; req_write = 2'b00;
    tick();
  endtask

  task automatic test_timeout();
    int n_access;
    logic seen_done;
    PREADY = 1'b0; PRDATA = 32'hFFFF_FFFF;
    req_addr[0 +: 32] = 32'h6000_0300; req_write[0] = 1'b0;
    req = 2'b01;
    n_access = 0; seen_done = 1'b0;
    for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
      tick();
      if (PENABLE === 1'b1) n_access++;
      if (done !== 2'b00) begin
        seen_done = 1'b1;
        n_checks++; if (done !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL to_done: got done=%b err=%0b rdata=%h want 01/1/0", done, rsp_err, rsp_rdata); end
        n_checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin n_fail++; $display("FAIL to_release: got psel=%0b pen=%0b want 0/0", PSEL, PENABLE); end
        req = 2'b00;
      end
    end
    n_checks++; if (!seen_done || n_access != 8) begin n_fail++; $display("FAIL to_length: got %0d access cycles done=%0b want 8/1", n_access, seen_done); end
    req = 2'b00; PRDATA = 32'h0;
    tick();
  endtask

  task automatic test_slverr();
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hCAFE_F00D;
    req_addr[0 +: 32] = 32'h6000_0400; req_write[0] = 1'b0;
    req = 2'b01;
    tick(); tick(); tick();
    n_checks++; if (done !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL slverr_done: got done=%b err=%0b rdata=%h want 01/1/cafef00d", done, rsp_err, rsp_rdata); end
    req = 2'b00; PSLVERR = 1'b0; PRDATA = 32'h0;
    tick();
  endtask

  task automatic test_reset_mid();
    // Requester 0 was granted last, so only a reset pointer lets it win again over 1.
    PREADY = 1'b0;
    req_addr[0 +: 32] = 32'h6000_0500; req_addr[32 +: 32] = 32'h6000_0600;
    req = 2'b01;
    tick(); tick(); tick();
    PRESET = 1'b1;
    tick();
    n_checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || done !== 2'b00) begin n_fail++; $display("FAIL rst_mid: got psel=%0b pen=%0b done=%b want 0/0/00", PSEL, PENABLE, done); end
    req = 2'b11;
    PRESET = 1'b0;
    tick();
    n_checks++; if (PSEL !== 1'b1 || PADDR !== 32'h6000_0500) begin n_fail++; $display("FAIL rst_first_grant: got psel=%0b addr=%h want 1/60000500", PSEL, PADDR); end
    PREADY = 1'b1;
    tick(); tick();
    n_checks++; if (done !== 2'b01) begin n_fail++; $display("FAIL rst_done: got done=%b want 01", done); end
    req = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_back_to_back();
    test_timeout();
    test_slverr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
